// File: rtl/systolic_drain_ctrl.sv
// Drains a SIZE x SIZE systolic PE result array as a row-major val/rdy word stream,
// then pulses acc_clr so the array can start its next accumulation.
module systolic_drain_ctrl #(
   parameter int unsigned SIZE   = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [SIZE*SIZE*DATA_W-1:0]   results,
   output logic                          send_val,
   input  logic                          send_rdy,
   output logic [DATA_W-1:0]             send_msg,
   output logic                          send_last,
   output logic                          acc_clr,
   output logic                          busy
);

   localparam int unsigned N     = SIZE * SIZE;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_SEND  = 2'b01;
   localparam logic [1:0] S_CLEAR = 2'b10;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic              load;
   logic [DATA_W-1:0] shadow [N];

   logic              val_nxt;
   logic              last_nxt;
   logic              clr_nxt;
   logic              busy_nxt;
   logic [DATA_W-1:0] msg_nxt;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state logic plus next values of the registered outputs
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load      = 1'b1;
               idx_nxt   = '0;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (send_rdy) begin
               if (idx == LAST_IDX) begin
                  idx_nxt   = '0;
                  state_nxt = S_CLEAR;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         S_CLEAR: begin
            state_nxt = S_IDLE;
         end
         default: begin
            idx_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase

      val_nxt  = (state_nxt == S_SEND);
      last_nxt = val_nxt && (idx_nxt == LAST_IDX);
      clr_nxt  = (state_nxt == S_CLEAR);
      busy_nxt = (state_nxt != S_IDLE);
      msg_nxt  = '0;
      // On the load edge the shadow is not yet written, so word 0 comes straight from results
      if (val_nxt) begin
         msg_nxt = load ? results[DATA_W-1:0] : shadow[idx_nxt];
      end
   end

   // Shadow buffer captures the array only on the IDLE->SEND edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(N); i++) begin
            shadow[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < int'(N); i++) begin
            shadow[i] <= results[i*DATA_W +: DATA_W];
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         send_val  <= 1'b0;
         send_last <= 1'b0;
         acc_clr   <= 1'b0;
         busy      <= 1'b0;
         send_msg  <= '0;
      end else begin
         send_val  <= val_nxt;
         send_last <= last_nxt;
         acc_clr   <= clr_nxt;
         busy      <= busy_nxt;
         send_msg  <= msg_nxt;
      end
   end

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Bench for systolic_drain_ctrl: queue-based drain model checked every cycle on a 2x2/8-bit
// instance, plus directed literal scenarios and a default-parameter 4x4/32-bit instance.
module tb_systolic_drain_ctrl;

   localparam int unsigned AS = 2;
   localparam int unsigned AW = 8;
   localparam int unsigned AN = AS * AS;
   localparam int unsigned BN = 16;
   localparam int unsigned BW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b0;
   logic              a_start = 1'b0;
   logic              a_rdy = 1'b0;
   logic [AN*AW-1:0]  a_res = '0;
   logic              a_val, a_last, a_clr, a_busy;
   logic [AW-1:0]     a_msg;

   logic              b_start = 1'b0;
   logic              b_rdy = 1'b1;
   logic [BN*BW-1:0]  b_res = '0;
   logic              b_val, b_last, b_clr, b_busy;
   logic [BW-1:0]     b_msg;

   systolic_drain_ctrl #(.SIZE(AS), .DATA_W(AW)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .results(a_res),
      .send_val(a_val), .send_rdy(a_rdy), .send_msg(a_msg),
      .send_last(a_last), .acc_clr(a_clr), .busy(a_busy));

   systolic_drain_ctrl dut_b (
      .clk(clk), .rst(rst), .start(b_start), .results(b_res),
      .send_val(b_val), .send_rdy(b_rdy), .send_msg(b_msg),
      .send_last(b_last), .acc_clr(b_clr), .busy(b_busy));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending words of the current drain, and a one-cycle clear flag
   int mq[$];
   bit m_clr = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_clr = 1'b0;
      end else if (m_clr) begin
         m_clr = 1'b0;
      end else if (mq.size() > 0) begin
         if (a_rdy) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_clr = 1'b1;
         end
      end else if (a_start) begin
         for (int k = 0; k < int'(AN); k++) mq.push_back(int'(a_res[k*AW +: AW]));
      end
   end

   int a_log[$];
   int a_clr_cnt = 0;
   int a_last_word = -1;

   // Per-cycle comparison of instance A against the model, away from the active edge
   always @(negedge clk) begin
      logic          e_val;
      logic          e_last;
      logic [AW-1:0] e_msg;
      e_val  = (mq.size() > 0);
      e_last = (mq.size() == 1);
      e_msg  = e_val ? AW'(mq[0]) : '0;
      chk("send_val",  64'(a_val),  64'(e_val));
      chk("send_last", 64'(a_last), 64'(e_last));
      chk("send_msg",  64'(a_msg),  64'(e_msg));
      chk("acc_clr",   64'(a_clr),  64'(m_clr));
      chk("busy",      64'(a_busy), 64'(e_val | m_clr));
      if (a_val && a_rdy) begin
         a_log.push_back(int'(a_msg));
         if (a_last) a_last_word = int'(a_msg);
      end
      if (a_clr) a_clr_cnt++;
   end

   int b_log[$];
   int b_clr_cnt = 0;
   int b_last_word = -1;

   always @(negedge clk) begin
      if (b_val && b_rdy) begin
         b_log.push_back(int'(b_msg));
         if (b_last) b_last_word = int'(b_msg);
      end
      if (b_clr) b_clr_cnt++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_a();
      a_start = 1'b1;
      cyc();
      a_start = 1'b0;
   endtask

   task automatic wait_idle_a(input string name);
      int n = 0;
      while (a_busy && n < 100) begin
         cyc();
         n++;
      end
      chk({name, "_timeout"}, 64'(n < 100), 64'(1));
   endtask

   task automatic clear_logs();
      a_log.delete();
      a_clr_cnt   = 0;
      a_last_word = -1;
   endtask

   task automatic chk_words(input string name);
      chk({name, "_count"}, 64'(a_log.size()), 64'(4));
      if (a_log.size() == 4) begin
         chk({name, "_w0"}, 64'(a_log[0]), 64'h11);
         chk({name, "_w1"}, 64'(a_log[1]), 64'h22);
         chk({name, "_w2"}, 64'(a_log[2]), 64'h33);
         chk({name, "_w3"}, 64'(a_log[3]), 64'h44);
      end
      chk({name, "_clr_cnt"}, 64'(a_clr_cnt), 64'(1));
   endtask

   localparam logic [AN*AW-1:0] BASE = {8'h44, 8'h33, 8'h22, 8'h11};

   initial begin
      int busy_cnt;
      int clr_at;
      int n;

      // Reset state
      #12;
      chk("rst_val",  64'(a_val),  64'(0));
      chk("rst_busy", 64'(a_busy), 64'(0));
      chk("rst_msg",  64'(a_msg),  64'(0));
      chk("rst_b_busy", 64'(b_busy), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // Basic drain with continuous ready
      a_res = BASE; a_rdy = 1'b1;
      clear_logs();
      pulse_a();
      busy_cnt = 0; clr_at = -1;
      for (int i = 0; i < 10; i++) begin
         if (a_busy) busy_cnt++;
         if (a_clr && clr_at < 0) clr_at = i + 1;
         cyc();
      end
      chk_words("basic");
      chk("basic_last_word", 64'(a_last_word), 64'h44);
      chk("basic_latency",   64'(clr_at),      64'(5));
      chk("basic_busy_cyc",  64'(busy_cnt),    64'(5));

      // Backpressure: three stalls, then 1,0,1,0, then ready
      clear_logs();
      a_rdy = 1'b0;
      pulse_a();
      repeat (3) cyc();
      chk("bp_stalled_msg", 64'(a_msg), 64'h11);
      for (int i = 0; i < 4; i++) begin
         a_rdy = (i % 2 == 0);
         cyc();
      end
      a_rdy = 1'b1;
      wait_idle_a("bp");
      cyc();
      chk_words("bp");

      // Shadow isolation
      clear_logs();
      pulse_a();
      a_res = '1;
      wait_idle_a("iso");
      cyc();
      chk_words("iso");
      a_res = BASE;

      // Start pulses during SEND and CLEAR are ignored
      clear_logs();
      pulse_a();
      cyc();
      pulse_a();
      n = 0;
      while (!a_clr && n < 20) begin cyc(); n++; end
      chk("ign_clr_seen", 64'(a_clr), 64'(1));
      pulse_a();
      repeat (3) cyc();
      chk("ign_idle", 64'(a_busy), 64'(0));
      chk_words("ign");

      // Reset after the second transfer
      clear_logs();
      pulse_a();
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("mid_val",  64'(a_val),  64'(0));
      chk("mid_busy", 64'(a_busy), 64'(0));
      chk("mid_msg",  64'(a_msg),  64'(0));
      chk("mid_xfers", 64'(a_log.size()), 64'(2));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("mid_no_clr", 64'(a_clr_cnt), 64'(0));
      clear_logs();
      pulse_a();
      wait_idle_a("mid");
      cyc();
      chk_words("mid");

      // Default-parameter instance: words 1..16, acc_clr 17 cycles after start
      for (int k = 0; k < int'(BN); k++) b_res[k*BW +: BW] = BW'(k + 1);
      b_start = 1'b1;
      cyc();
      b_start = 1'b0;
      clr_at = -1;
      for (int i = 0; i < 25; i++) begin
         if (b_clr && clr_at < 0) clr_at = i + 1;
         cyc();
      end
      chk("b_count", 64'(b_log.size()), 64'(16));
      if (b_log.size() == 16) begin
         for (int k = 0; k < 16; k++) chk("b_word", 64'(b_log[k]), 64'(k + 1));
      end
      chk("b_last_word", 64'(b_last_word), 64'(16));
      chk("b_latency",   64'(clr_at),      64'(17));
      chk("b_clr_cnt",   64'(b_clr_cnt),   64'(1));

      // Randomized traffic against the model
      for (int t = 0; t < 2000; t++) begin
         a_rdy   = ($urandom_range(0, 2) != 0);
         a_start = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) a_res = AN*AW'($urandom());
         if ($urandom_range(0, 150) == 0) begin
            rst = 1'b0;
            #2;
            rst = 1'b1;
         end
         cyc();
      end
      a_start = 1'b0;
      a_rdy   = 1'b1;
      wait_idle_a("rand");
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_drain_ctrl.md
SYSTOLIC_DRAIN_CTRL -- requirements
Module: systolic_drain_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, giving the PE array dimension (SIZE x SIZE results).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the width of one PE accumulator and one output message.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle pulse indicating the array has finished MAC and results are final.
REQ-006 The block SHALL have port results, input, SIZE*SIZE*DATA_W bits: flattened PE accumulators, PE(r,c) at bits [(r*SIZE+c)*DATA_W +: DATA_W].
REQ-007 The block SHALL have port send_val, output, 1 bit: output message valid.
REQ-008 The block SHALL have port send_rdy, input, 1 bit: downstream ready.
REQ-009 The block SHALL have port send_msg, output, DATA_W bits: current result word.
REQ-010 The block SHALL have port send_last, output, 1 bit: high with send_val on the final word of a drain.
REQ-011 The block SHALL have port acc_clr, output, 1 bit: one-cycle pulse to clear the PE accumulators after the drain.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL implement exactly three states: IDLE, SEND, CLEAR.
REQ-014 In IDLE, with start=1 at a rising edge, the block SHALL copy all SIZE*SIZE words of results into an internal shadow buffer, set word index to 0, and enter SEND.
REQ-015 start SHALL be ignored in SEND and CLEAR; the shadow buffer SHALL NOT change outside the IDLE->SEND edge.
REQ-016 send_val SHALL be 1 exactly when state is SEND, so that send_val first rises one cycle after start is sampled.
REQ-017 send_msg SHALL equal shadow word[idx], in row-major order (idx = r*SIZE+c), and SHALL equal 0 when send_val=0.
REQ-018 A transfer SHALL occur only on a cycle with send_val=1 and send_rdy=1; on each transfer idx SHALL increment by 1.
REQ-019 While send_val=1 and send_rdy=0, send_msg, send_last and idx SHALL hold stable.
REQ-020 send_last SHALL be 1 exactly when state is SEND and idx = SIZE*SIZE-1.
REQ-021 A transfer with send_last=1 SHALL move the state to CLEAR and reset idx to 0; idx SHALL never exceed SIZE*SIZE-1.
REQ-022 In CLEAR, acc_clr SHALL be 1 for exactly that one cycle, after which the state SHALL return to IDLE unconditionally.
REQ-023 acc_clr SHALL be 0 in IDLE and SEND.
REQ-024 send_rdy held 1 continuously SHALL yield SIZE*SIZE back-to-back transfers, making start-to-acc_clr latency SIZE*SIZE+1 cycles.
REQ-025 send_rdy asserted without send_val SHALL have no effect.
REQ-026 An invalid state encoding SHALL transition to IDLE on the next edge.
REQ-027 All outputs SHALL be driven from registered state and idx, with no combinational path from send_rdy or start to any output.

Reset
REQ-028 While rst=0, the block SHALL immediately force state to IDLE, idx to 0, and the shadow buffer to 0, independent of clk.
REQ-029 While rst=0, send_val, send_last, acc_clr and busy SHALL be 0 and send_msg SHALL be 0.
REQ-030 Reset asserted mid-drain SHALL abort the drain: no further transfers and no acc_clr pulse.
REQ-031 After rst is released, start SHALL be accepted on the first rising edge.

Verification
REQ-032 Basic drain (SIZE=2, DATA_W=8): results={PE00=0x11, PE01=0x22, PE10=0x33, PE11=0x44}, start pulse, send_rdy=1 -> words 0x11, 0x22, 0x33, 0x44 on four consecutive cycles; send_last high only with 0x44; acc_clr high on the following cycle; busy high for 5 cycles.
REQ-033 Backpressure: same stimulus with send_rdy=0 for 3 cycles after the first send_val, then toggling 1,0,1,0 -> same word order; send_msg stable during stalls; exactly 4 transfers.
REQ-034 Shadow isolation: change results to all 0xFF one cycle after start -> output words remain 0x11, 0x22, 0x33, 0x44.
REQ-035 Ignored start: pulse start again during SEND and during CLEAR -> no restart and no extra words; block returns to IDLE after one acc_clr.
REQ-036 Reset mid-drain: assert rst=0 after the second transfer -> send_val, busy and send_msg go to 0 immediately, with no acc_clr; after release, a new start drains all 4 words from idx 0.
REQ-037 Default parameters (SIZE=4, DATA_W=32): results word k = k+1 and send_rdy=1 -> 16 words 1..16 in order, send_last on 16, and acc_clr 17 cycles after start.
